sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one single-port synchronous SRAM between the IF fetch port and the EX data port of mycpu_core.
//  Sits between the core's inst_sram_*/data_sram_* buses and the physical memory.
//  Serialises same-cycle conflicts and raises a stall request to CTRL.
//  Holds each port's read data so ID/MEM see stable rdata across stalls.
// PARAMETERS
//  ADDR_W  32  address width, both ports and memory
//  DATA_W  32  data width; byte-enable width is DATA_W/8
//  CNT_W   16  width of saturating conflict counter
// PORTS
//  clk          in   1         single clock, all state on rising edge
//  rst          in   1         reset, synchronous, active-high
//  inst_en      in   1         fetch request
//  inst_wen     in   DATA_W/8  fetch byte-write enables (normally 0)
//  inst_addr    in   ADDR_W    fetch address
//  inst_wdata   in   DATA_W    fetch write data
//  inst_rdata   out  DATA_W    fetch read data
//  data_en      in   1         load/store request
//  data_wen     in   DATA_W/8  store byte enables; 0 = load
//  data_addr    in   ADDR_W    load/store address
//  data_wdata   in   DATA_W    store data
//  data_rdata   out  DATA_W    load data
//  mem_en       out  1         SRAM enable
//  mem_wen      out  DATA_W/8  SRAM byte enables
//  mem_addr     out  ADDR_W    SRAM address
//  mem_wdata    out  DATA_W    SRAM write data
//  mem_rdata    in   DATA_W    SRAM read data, valid 1 cycle after mem_en
//  stallreq     out  1         stall request to CTRL
//  conflict_cnt out  CNT_W     saturating count of conflicts since reset
// BEHAVIOUR
//  States: PASS, REPLAY. Reset (sync, rst=1): state=PASS, rsp tags cleared, held rdata=0, conflict_cnt=0.
//   While rst=1, mem_en=0, mem_wen=0, stallreq=0, inst_rdata=0, data_rdata=0.
//  PASS, only one port requests: mem_* = that port's bus, combinational; stallreq=0; next=PASS.
//  PASS, neither requests: mem_en=0, mem_wen=0, mem_addr/wdata don't-care; stallreq=0.
//  PASS, both request (conflict):
//   - data port granted; inst en/wen/addr/wdata latched in replay buffer; stallreq=1.
//   - conflict_cnt+1, saturating at 2^CNT_W-1; next=REPLAY.
//  REPLAY: mem_* = replay buffer; stallreq=1; core-side requests ignored, no grant, no latch; next=PASS.
//   Core-side requests are not re-latched in REPLAY; CTRL holds pipeline so requests repeat in next PASS.
//  Stall cost: 2 cycles (conflict + replay) per conflict.
//  Response routing: registered per-port tag set when the port's read is issued (mem_en=1, mem_wen=0).
//  Cycle after a tagged read: port rdata = mem_rdata (pass-through); mem_rdata also latched to held reg.
//  All other cycles: port rdata = held reg, stable until next tagged read for that port completes.
//  Write (any mem_wen bit set): no tag, held rdata unchanged, rdata for that port stays prior value.
//  Ordering: in a conflict, the data access reaches SRAM one cycle before the replayed fetch.
//   Same-address store then fetch: fetch returns stored data.
//  Reset mid-REPLAY: replay dropped, no mem access issued; state=PASS next cycle; pending tags cleared.
//  Back-to-back conflicts: PASS->REPLAY->PASS->REPLAY; stallreq stays 1 throughout; each counted.
// TESTING
//  1 Reset: rst=1 two cycles with both ports requesting -> mem_en=0, stallreq=0, conflict_cnt=0, rdata=0.
//  2 Fetch only: inst_en=1, addr=0x100, mem returns 0xAAAA0001 next cycle -> inst_rdata=0xAAAA0001.
//   inst_rdata still 0xAAAA0001 while idle; stallreq=0 throughout.
//  3 Conflict, load addr 0x200 + fetch 0x104:
//   - c0: mem_addr=0x200, stallreq=1.
//   - c1: mem_addr=0x104, stallreq=1; data_rdata=M[0x200].
//   - c2: inst_rdata=M[0x104]; stallreq=0; data_rdata still M[0x200]; conflict_cnt=1.
//  4 Conflict with store 0x300 wen=0xF wdata=0x12345678 + fetch 0x300:
//   - store issued first, then fetch; inst_rdata=0x12345678.
//   - data_rdata unchanged.
//  5 rst=1 in REPLAY cycle -> no mem access that cycle; next cycle PASS, stallreq=0; counter=0.
//  6 CNT_W=2, five conflicts -> conflict_cnt 1,2,3,3,3 (saturates, no wrap).

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Single-port SRAM style bus: request fields flow master->slave, read data flows back.
// Used for the fetch port, the data port and the physical memory side of the arbiter.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  en;
    logic [DATA_W/8-1:0]   wen;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     rdata;

    modport master (output en, wen, addr, wdata, input rdata);
    modport slave  (input en, wen, addr, wdata, output rdata);
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch and data ports.
// Conflicts grant the data port first and replay the fetch the next cycle under stall.
module sram_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_port_arbiter_if.slave   inst_bus,
    sram_port_arbiter_if.slave   data_bus,
    sram_port_arbiter_if.master  mem_bus,
    output logic                 stallreq,
    output logic [CNT_W-1:0]     conflict_cnt
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [0:0] {
        ST_PASS   = 1'b0,
        ST_REPLAY = 1'b1
    } state_t;

    state_t              state_r;
    logic                rp_en_r;
    logic [BE_W-1:0]     rp_wen_r;
    logic [ADDR_W-1:0]   rp_addr_r;
    logic [DATA_W-1:0]   rp_wdata_r;
    logic                inst_tag_r;
    logic                data_tag_r;
    logic [DATA_W-1:0]   inst_hold_r;
    logic [DATA_W-1:0]   data_hold_r;
    logic [CNT_W-1:0]    cnt_r;

    logic                mem_en_s;
    logic [BE_W-1:0]     mem_wen_s;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_s;
    logic                stall_s;
    logic                grant_inst_s;
    logic                grant_data_s;
    logic                conflict_s;
    logic                inst_rd_s;
    logic                data_rd_s;

    // Memory-side mux and grant decision; reset suppresses every access.
    always_comb begin
        mem_en_s     = 1'b0;
        mem_wen_s    = {BE_W{1'b0}};
        mem_addr_s   = {ADDR_W{1'b0}};
        mem_wdata_s  = {DATA_W{1'b0}};
        stall_s      = 1'b0;
        grant_inst_s = 1'b0;
        grant_data_s = 1'b0;
        conflict_s   = 1'b0;
        if (rst) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                ST_REPLAY: begin
                    mem_en_s     = rp_en_r;
                    mem_wen_s    = rp_wen_r;
                    mem_addr_s   = rp_addr_r;
                    mem_wdata_s  = rp_wdata_r;
                    stall_s      = 1'b1;
                    grant_inst_s = rp_en_r;
                end
                ST_PASS: begin
                    if (data_bus.en) begin
                        mem_en_s     = 1'b1;
                        mem_wen_s    = data_bus.wen;
                        mem_addr_s   = data_bus.addr;
                        mem_wdata_s  = data_bus.wdata;
                        grant_data_s = 1'b1;
                        stall_s      = inst_bus.en;
                        conflict_s   = inst_bus.en;
                    end else if (inst_bus.en) begin
                        mem_en_s     = 1'b1;
                        mem_wen_s    = inst_bus.wen;
                        mem_addr_s   = inst_bus.addr;
                        mem_wdata_s  = inst_bus.wdata;
                        grant_inst_s = 1'b1;
                    end else begin
                        mem_en_s = 1'b0;
                    end
                end
                default: begin
                    stall_s = 1'b0;
                end
            endcase
        end
    end

    // Only reads are tagged; a write leaves the port's held data untouched.
    assign inst_rd_s = grant_inst_s & mem_en_s & ~(|mem_wen_s);
    assign data_rd_s = grant_data_s & mem_en_s & ~(|mem_wen_s);

    // State, replay buffer, response tags, held read data and conflict counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_PASS;
            rp_en_r     <= 1'b0;
            rp_wen_r    <= {BE_W{1'b0}};
            rp_addr_r   <= {ADDR_W{1'b0}};
            rp_wdata_r  <= {DATA_W{1'b0}};
            inst_tag_r  <= 1'b0;
            data_tag_r  <= 1'b0;
            inst_hold_r <= {DATA_W{1'b0}};
            data_hold_r <= {DATA_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            inst_tag_r <= inst_rd_s;
            data_tag_r <= data_rd_s;
            if (inst_tag_r) begin
                inst_hold_r <= mem_bus.rdata;
            end
            if (data_tag_r) begin
                data_hold_r <= mem_bus.rdata;
            end
            case (state_r)
                ST_PASS: begin
                    if (conflict_s) begin
                        state_r    <= ST_REPLAY;
                        rp_en_r    <= inst_bus.en;
                        rp_wen_r   <= inst_bus.wen;
                        rp_addr_r  <= inst_bus.addr;
                        rp_wdata_r <= inst_bus.wdata;
                        if (cnt_r != {CNT_W{1'b1}}) begin
                            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_REPLAY: begin
                    state_r <= ST_PASS;
                end
                default: begin
                    state_r <= ST_PASS;
                end
            endcase
        end
    end

    // Read data: pass-through in the response cycle, held value otherwise.
    always_comb begin
        inst_bus.rdata = {DATA_W{1'b0}};
        data_bus.rdata = {DATA_W{1'b0}};
        if (rst) begin
            inst_bus.rdata = {DATA_W{1'b0}};
            data_bus.rdata = {DATA_W{1'b0}};
        end else begin
            inst_bus.rdata = inst_tag_r ? mem_bus.rdata : inst_hold_r;
            data_bus.rdata = data_tag_r ? mem_bus.rdata : data_hold_r;
        end
    end

    assign mem_bus.en    = mem_en_s;
    assign mem_bus.wen   = mem_wen_s;
    assign mem_bus.addr  = mem_addr_s;
    assign mem_bus.wdata = mem_wdata_s;
    assign stallreq      = stall_s;
    assign conflict_cnt  = cnt_r;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: a behavioural SRAM answers the memory side,
// expected read data is queued at issue time and popped when the port delivers it.
module tb_sram_port_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   passed;

    logic [31:0] exp_inst_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] sram [256];

    logic        stallreq;
    logic [15:0] conflict_cnt;
    logic        stallreq2;
    logic [1:0]  conflict_cnt2;

    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();
    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst2_if ();
    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data2_if ();
    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem2_if ();

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .inst_bus(inst_if), .data_bus(data_if),
        .mem_bus(mem_if), .stallreq(stallreq), .conflict_cnt(conflict_cnt)
    );

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .inst_bus(inst2_if), .data_bus(data2_if),
        .mem_bus(mem2_if), .stallreq(stallreq2), .conflict_cnt(conflict_cnt2)
    );

    assign mem2_if.rdata = 32'h0000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    // Behavioural SRAM: one-cycle read latency, byte-enabled writes, preloaded on reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) sram[i] <= pat(32'(i) << 2);
            sram[8'h40] <= 32'hAAAA_0001;
            mem_if.rdata <= 32'h0000_0000;
        end else if (mem_if.en) begin
            if (|mem_if.wen) begin
                for (int b = 0; b < 4; b++)
                    if (mem_if.wen[b]) sram[mem_if.addr[9:2]][8*b +: 8] <= mem_if.wdata[8*b +: 8];
            end else begin
                mem_if.rdata <= sram[mem_if.addr[9:2]];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ie, input logic [31:0] ia, input logic de,
                         input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
        inst_if.en = ie; inst_if.wen = 4'h0; inst_if.addr = ia; inst_if.wdata = 32'h0;
        data_if.en = de; data_if.wen = dw;   data_if.addr = da; data_if.wdata = dd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 32'h0000_0100, 1'b1, 4'h0, 32'h0000_0200, 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (mem_if.en !== 1'b0) $display("FAIL rst_mem_en got %b want 0", mem_if.en); else passed++;
            checks++; if (stallreq !== 1'b0) $display("FAIL rst_stall got %b want 0", stallreq); else passed++;
            checks++; if (conflict_cnt !== 16'd0) $display("FAIL rst_cnt got %0d want 0", conflict_cnt); else passed++;
            checks++; if (inst_if.rdata !== 32'h0) $display("FAIL rst_inst_rdata got %h want 0", inst_if.rdata); else passed++;
            checks++; if (data_if.rdata !== 32'h0) $display("FAIL rst_data_rdata got %h want 0", data_if.rdata); else passed++;
            step();
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_fetch_only();
        logic [31:0] exp;
        drive(1'b1, 32'h0000_0100, 1'b0, 4'h0, 32'h0, 32'h0);
        exp_inst_q.push_back(32'hAAAA_0001);
        @(negedge clk);
        checks++; if (mem_if.en !== 1'b1 || mem_if.addr !== 32'h100 || mem_if.wen !== 4'h0)
            $display("FAIL fetch_issue got en=%b addr=%h wen=%h want 1/100/0", mem_if.en, mem_if.addr, mem_if.wen); else passed++;
        checks++; if (stallreq !== 1'b0) $display("FAIL fetch_stall0 got %b want 0", stallreq); else passed++;
        step();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        exp = (exp_inst_q.size() > 0) ? exp_inst_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (inst_if.rdata !== exp) $display("FAIL fetch_rdata got %h want %h", inst_if.rdata, exp); else passed++;
        checks++; if (stallreq !== 1'b0) $display("FAIL fetch_stall1 got %b want 0", stallreq); else passed++;
        step();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (inst_if.rdata !== 32'hAAAA_0001) $display("FAIL fetch_hold got %h want aaaa0001", inst_if.rdata); else passed++;
            checks++; if (mem_if.en !== 1'b0 || stallreq !== 1'b0)
                $display("FAIL fetch_idle got en=%b stall=%b want 0/0", mem_if.en, stallreq); else passed++;
            step();
        end
    endtask

    task automatic test_conflict_load();
        logic [31:0] exp;
        drive(1'b1, 32'h0000_0104, 1'b1, 4'h0, 32'h0000_0200, 32'h0);
        exp_data_q.push_back(pat(32'h200));
        exp_inst_q.push_back(pat(32'h104));
        @(negedge clk);
        checks++; if (mem_if.addr !== 32'h200 || mem_if.en !== 1'b1 || stallreq !== 1'b1)
            $display("FAIL ld_c0 got addr=%h en=%b stall=%b want 200/1/1", mem_if.addr, mem_if.en, stallreq); else passed++;
        step();
        @(negedge clk);
        checks++; if (mem_if.addr !== 32'h104 || mem_if.wen !== 4'h0 || stallreq !== 1'b1)
            $display("FAIL ld_c1 got addr=%h wen=%h stall=%b want 104/0/1", mem_if.addr, mem_if.wen, stallreq); else passed++;
        exp = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (data_if.rdata !== exp) $display("FAIL ld_data_rdata got %h want %h", data_if.rdata, exp); else passed++;
        step();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        exp = (exp_inst_q.size() > 0) ? exp_inst_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (inst_if.rdata !== exp) $display("FAIL ld_inst_rdata got %h want %h", inst_if.rdata, exp); else passed++;
        checks++; if (stallreq !== 1'b0) $display("FAIL ld_c2_stall got %b want 0", stallreq); else passed++;
        checks++; if (data_if.rdata !== pat(32'h200)) $display("FAIL ld_data_hold got %h want %h", data_if.rdata, pat(32'h200)); else passed++;
        checks++; if (conflict_cnt !== 16'd1) $display("FAIL ld_cnt got %0d want 1", conflict_cnt); else passed++;
        step();
    endtask

    task automatic test_conflict_store();
        logic [31:0] exp;
        drive(1'b1, 32'h0000_0300, 1'b1, 4'hF, 32'h0000_0300, 32'h1234_5678);
        exp_inst_q.push_back(32'h1234_5678);
        @(negedge clk);
        checks++; if (mem_if.wen !== 4'hF || mem_if.addr !== 32'h300 || mem_if.wdata !== 32'h1234_5678 || stallreq !== 1'b1)
            $display("FAIL st_c0 got wen=%h addr=%h wdata=%h stall=%b want f/300/12345678/1",
                     mem_if.wen, mem_if.addr, mem_if.wdata, stallreq); else passed++;
        step();
        @(negedge clk);
        checks++; if (mem_if.addr !== 32'h300 || mem_if.wen !== 4'h0 || mem_if.en !== 1'b1)
            $display("FAIL st_c1 got addr=%h wen=%h en=%b want 300/0/1", mem_if.addr, mem_if.wen, mem_if.en); else passed++;
        checks++; if (data_if.rdata !== pat(32'h200)) $display("FAIL st_data_c1 got %h want %h", data_if.rdata, pat(32'h200)); else passed++;
        step();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        exp = (exp_inst_q.size() > 0) ? exp_inst_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (inst_if.rdata !== exp) $display("FAIL st_inst_rdata got %h want %h", inst_if.rdata, exp); else passed++;
        checks++; if (data_if.rdata !== pat(32'h200)) $display("FAIL st_data_c2 got %h want %h", data_if.rdata, pat(32'h200)); else passed++;
        checks++; if (conflict_cnt !== 16'd2) $display("FAIL st_cnt got %0d want 2", conflict_cnt); else passed++;
        step();
    endtask

    task automatic test_reset_in_replay();
        logic [31:0] exp;
        drive(1'b1, 32'h0000_0108, 1'b1, 4'h0, 32'h0000_0200, 32'h0);
        @(negedge clk);
        checks++; if (stallreq !== 1'b1) $display("FAIL rr_c0_stall got %b want 1", stallreq); else passed++;
        step();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_if.en !== 1'b0 || stallreq !== 1'b0)
            $display("FAIL rr_in_rst got en=%b stall=%b want 0/0", mem_if.en, stallreq); else passed++;
        checks++; if (data_if.rdata !== 32'h0) $display("FAIL rr_rst_rdata got %h want 0", data_if.rdata); else passed++;
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (mem_if.en !== 1'b0 || stallreq !== 1'b0)
            $display("FAIL rr_after got en=%b stall=%b want 0/0", mem_if.en, stallreq); else passed++;
        checks++; if (conflict_cnt !== 16'd0) $display("FAIL rr_cnt got %0d want 0", conflict_cnt); else passed++;
        checks++; if (inst_if.rdata !== 32'h0 || data_if.rdata !== 32'h0)
            $display("FAIL rr_tags got inst=%h data=%h want 0/0", inst_if.rdata, data_if.rdata); else passed++;
        step();
        drive(1'b1, 32'h0000_010C, 1'b0, 4'h0, 32'h0, 32'h0);
        exp_inst_q.push_back(pat(32'h10C));
        @(negedge clk);
        checks++; if (mem_if.addr !== 32'h10C || stallreq !== 1'b0)
            $display("FAIL rr_pass got addr=%h stall=%b want 10c/0", mem_if.addr, stallreq); else passed++;
        step();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        exp = (exp_inst_q.size() > 0) ? exp_inst_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (inst_if.rdata !== exp) $display("FAIL rr_fetch got %h want %h", inst_if.rdata, exp); else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        logic [1:0] exp_cnt;
        inst2_if.en = 1'b1; inst2_if.wen = 4'h0; inst2_if.addr = 32'h0000_0400; inst2_if.wdata = 32'h0;
        data2_if.en = 1'b1; data2_if.wen = 4'h0; data2_if.addr = 32'h0000_0500; data2_if.wdata = 32'h0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n = (k + 1) / 2;
            exp_cnt = (n > 3) ? 2'd3 : 2'(n);
            checks++; if (stallreq2 !== 1'b1) $display("FAIL b2b_stall k=%0d got %b want 1", k, stallreq2); else passed++;
            checks++; if (conflict_cnt2 !== exp_cnt) $display("FAIL b2b_cnt k=%0d got %0d want %0d", k, conflict_cnt2, exp_cnt); else passed++;
            checks++; if (mem2_if.addr !== ((k % 2 == 0) ? 32'h500 : 32'h400))
                $display("FAIL b2b_addr k=%0d got %h", k, mem2_if.addr); else passed++;
            step();
        end
        inst2_if.en = 1'b0;
        data2_if.en = 1'b0;
        @(negedge clk);
        checks++; if (stallreq2 !== 1'b0 || conflict_cnt2 !== 2'd3)
            $display("FAIL b2b_end got stall=%b cnt=%0d want 0/3", stallreq2, conflict_cnt2); else passed++;
        step();
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        inst2_if.en = 1'b0; inst2_if.wen = 4'h0; inst2_if.addr = 32'h0; inst2_if.wdata = 32'h0;
        data2_if.en = 1'b0; data2_if.wen = 4'h0; data2_if.addr = 32'h0; data2_if.wdata = 32'h0;
        #1;
        test_reset();
        test_fetch_only();
        test_conflict_load();
        test_conflict_store();
        test_reset_in_replay();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
